// File: rtl/table_lookup_arbiter_if.sv
// Request, response and lookup-engine buses of the shared table-lookup arbiter.
// master = client/engine side, slave = arbiter side.
interface table_lookup_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ*4-1:0] req_control;

  logic [7:0]           lkp_data;
  logic [3:0]           lkp_control;
  logic                 lkp_valid;
  logic [15:0]          lkp_result;
  logic [3:0]           lkp_status;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_result;
  logic [3:0]           rsp_status;

  modport master (
    output req_valid, req_data, req_control, rsp_ready, lkp_result, lkp_status,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_status,
           lkp_data, lkp_control, lkp_valid
  );

  modport slave (
    input  req_valid, req_data, req_control, rsp_ready, lkp_result, lkp_status,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_status,
           lkp_data, lkp_control, lkp_valid
  );
endinterface

// File: rtl/table_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational lookup engine among NUM_REQ clients.
// Define TABLE_ARB_STATS_EN to add saturating grant/stall counters.
module table_lookup_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  table_lookup_arbiter_if.slave  bus
`ifdef TABLE_ARB_STATS_EN
  ,
  output logic [15:0]            stat_grants,
  output logic [15:0]            stat_stalls
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CNT_W = ID_W + 1;
  localparam logic [CNT_W-1:0] NUM_REQ_C = CNT_W'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               grant;
  logic [CNT_W-1:0]   cand;
  logic [NUM_REQ-1:0] ready;

  // Search upward from rr_ptr with wrap-around; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CNT_W'(k);
      if (cand >= NUM_REQ_C) cand = cand - NUM_REQ_C;
      if (!win_found && bus.req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  assign grant = (state == IDLE) && win_found;

  always_comb begin
    ready = '0;
    if (rst_n && grant) ready[win_id] = 1'b1;
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers feed the engine; its output is captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      bus.lkp_data    <= '0;
      bus.lkp_control <= '0;
      bus.lkp_valid   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_status  <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          bus.lkp_data    <= bus.req_data[8*win_id +: 8];
          bus.lkp_control <= bus.req_control[4*win_id +: 4];
          bus.rsp_id      <= win_id;
          bus.lkp_valid   <= 1'b1;
        end
        LOOKUP: begin
          bus.rsp_result <= bus.lkp_result;
          bus.rsp_status <= bus.lkp_status;
          bus.rsp_valid  <= 1'b1;
          bus.lkp_valid  <= 1'b0;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          rr_ptr        <= (bus.rsp_id == LAST_ID) ? '0 : bus.rsp_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef TABLE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
      if (state == RESP && !bus.rsp_ready && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_table_lookup_arbiter.sv
// Directed table-driven bench for table_lookup_arbiter with a simple lookup-engine model.
module tb_table_lookup_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  table_lookup_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef TABLE_ARB_STATS_EN
  logic [15:0] stat_grants, stat_stalls;
  table_lookup_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );
`else
  table_lookup_arbiter #(.NUM_REQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Engine model: known table entries, otherwise an easily recognised pattern.
  always_comb begin
    case ({bus.lkp_control, bus.lkp_data})
      12'h235: begin bus.lkp_result = 16'h6666; bus.lkp_status = 4'h3; end
      12'h005: begin bus.lkp_result = 16'h0055; bus.lkp_status = 4'h1; end
      12'h303: begin bus.lkp_result = 16'h1234; bus.lkp_status = 4'h1; end
      default: begin
        bus.lkp_result = {4'hA, bus.lkp_control, bus.lkp_data};
        bus.lkp_status = bus.lkp_control;
      end
    endcase
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [15:0] ctrl;
    logic [1:0]  win;
    logic [15:0] res;
    logic [3:0]  stat;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at an IDLE-state negedge; returns at the RESP-state negedge.
  task automatic run_txn(input vec_t v, input logic hold_ready);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.win;
    bus.req_valid   = v.valid;
    bus.req_data    = v.data;
    bus.req_control = v.ctrl;
    bus.rsp_ready   = hold_ready;
    #1;
    chk("req_ready_grant", 32'(bus.req_ready), 32'(onehot));
    @(negedge clk);
    chk("lkp_valid_lookup", 32'(bus.lkp_valid), 32'd1);
    chk("lkp_data", 32'(bus.lkp_data), 32'(v.data[8*v.win +: 8]));
    chk("lkp_control", 32'(bus.lkp_control), 32'(v.ctrl[4*v.win +: 4]));
    chk("req_ready_lookup", 32'(bus.req_ready), 32'd0);
    chk("rsp_valid_lookup", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(v.win));
    chk("rsp_result", 32'(bus.rsp_result), 32'(v.res));
    chk("rsp_status", 32'(bus.rsp_status), 32'(v.stat));
    chk("lkp_valid_resp", 32'(bus.lkp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp;
    vec[0]  = '{4'hF, 32'h05050505, 16'h0000, 2'd0, 16'h0055, 4'h1};
    vec[1]  = '{4'hF, 32'h05050505, 16'h0000, 2'd1, 16'h0055, 4'h1};
    vec[2]  = '{4'hF, 32'h05050505, 16'h0000, 2'd2, 16'h0055, 4'h1};
    vec[3]  = '{4'hF, 32'h05050505, 16'h0000, 2'd3, 16'h0055, 4'h1};
    vec[4]  = '{4'hF, 32'h05050505, 16'h0000, 2'd0, 16'h0055, 4'h1};
    vec[5]  = '{4'h1, 32'h00000035, 16'h0002, 2'd0, 16'h6666, 4'h3};
    vec[6]  = '{4'h8, 32'hC7000000, 16'h9000, 2'd3, 16'hA9C7, 4'h9};
    vec[7]  = '{4'h6, 32'h00031100, 16'h0340, 2'd1, 16'hA411, 4'h4};
    vec[8]  = '{4'h6, 32'h00031100, 16'h0340, 2'd2, 16'h1234, 4'h1};
    vec[9]  = '{4'hF, 32'h5AFFEEDD, 16'h6FED, 2'd3, 16'hA65A, 4'h6};
    vec[10] = '{4'h9, 32'h77000035, 16'h7002, 2'd0, 16'h6666, 4'h3};
    vec[11] = '{4'h8, 32'hC7000000, 16'h9000, 2'd3, 16'hA9C7, 4'h9};

    bus.req_valid   = 4'hF;
    bus.req_data    = 32'h05050505;
    bus.req_control = 16'h0000;
    bus.rsp_ready   = 1'b1;
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_lkp_valid", 32'(bus.lkp_valid), 32'd0);
    chk("reset_lkp_data", 32'(bus.lkp_data), 32'd0);
    chk("reset_rsp_fields", {12'd0, bus.rsp_result, bus.rsp_status}, 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'h0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      run_txn(vec[i], 1'b1);
    end

`ifdef TABLE_ARB_STATS_EN
    chk("stat_grants_12", 32'(stat_grants), 32'd12);
    chk("stat_stalls_0", 32'(stat_stalls), 32'd0);
`endif

    // Backpressure: five RESP cycles with rsp_ready low, other requesters valid.
    bp = '{4'h2, 32'h00000500, 16'h0000, 2'd1, 16'h0055, 4'h1};
    @(negedge clk);
    run_txn(bp, 1'b0);
    bus.req_valid = 4'hF;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_rsp_result", 32'(bus.rsp_result), 32'h0055);
      chk("bp_rsp_status", 32'(bus.rsp_status), 32'h1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
`ifdef TABLE_ARB_STATS_EN
    chk("stat_stalls_5", 32'(stat_stalls), 32'd5);
`endif
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_released_req_ready", 32'(bus.req_ready), 32'd0);

    // Reset during LOOKUP: pointer is 2 here, so requester 3 would lose to 1 only after reset.
    bus.req_valid   = 4'h8;
    bus.req_data    = 32'hC7000000;
    bus.req_control = 16'h9000;
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    chk("pre_rst_lkp_valid", 32'(bus.lkp_valid), 32'd1);
    bus.req_valid = 4'hA;
    rst_n = 1'b0;
    #1;
    chk("rst_lkp_valid", 32'(bus.lkp_valid), 32'd0);
    chk("rst_lkp_data", 32'(bus.lkp_data), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    bp = '{4'hA, 32'hC7001100, 16'h9040, 2'd1, 16'hA411, 4'h4};
    run_txn(bp, 1'b1);
`ifdef TABLE_ARB_STATS_EN
    chk("stat_grants_after_rst", 32'(stat_grants), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/table_lookup_arbiter.md
Name: table_lookup_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational table-lookup engine (8-bit data / 4-bit control in, 16-bit result / 4-bit status out) among NUM_REQ requesters. It accepts one request at a time over valid/ready and drives the operands to the engine from registers. It captures the engine output and returns it on a single shared response channel, tagged with the requester ID. It sits between client pipelines and the lookup datapath in the table top level.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(NUM_REQ), width of the requester ID. Localparam, not overridable.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
req_data  input  NUM_REQ*8  packed operands; requester i occupies [8i+7:8i].
req_control  input  NUM_REQ*4  packed controls; requester i occupies [4i+3:4i].
lkp_data  output  8  operand to the lookup engine (registered).
lkp_control  output  4  control to the lookup engine (registered).
lkp_valid  output  1  high while the engine operands are meaningful.
lkp_result  input  16  engine result (combinational from lkp_data/lkp_control).
lkp_status  input  4  engine status.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accept.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_result  output  16  captured result.
rsp_status  output  4  captured status.

Behaviour:
- Reset (async assert, sync release) values:
  - FSM = IDLE, rr_ptr = 0.
  - lkp_data = 0, lkp_control = 0, lkp_valid = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_status = 0.
  - req_ready is combinational and is 0 during reset.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If any req_valid is high, select winner w = first set bit searching upward from rr_ptr, with wrap-around.
  - req_ready[w] = 1 combinationally in this cycle only; the handshake completes this cycle.
  - On the edge: lkp_data <= req_data[w], lkp_control <= req_control[w], rsp_id <= w, lkp_valid <= 1, go to LOOKUP.
  - If no req_valid is high: all req_ready = 0, stay in IDLE.
- LOOKUP (exactly 1 cycle):
  - Engine settles. On the edge: rsp_result <= lkp_result, rsp_status <= lkp_status, rsp_valid <= 1, lkp_valid <= 0, go to RESP.
  - lkp_data and lkp_control hold their values (not cleared).
- RESP:
  - rsp_valid = 1 and all rsp_* outputs are stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod NUM_REQ, go to IDLE.
  - req_ready = 0 throughout LOOKUP and RESP.
- Latency and throughput:
  - Request accept to rsp_valid high = 2 cycles.
  - Minimum 3 cycles per transaction; no overlap of transactions.
- Fairness:
  - The requester just served has lowest priority next time.
  - With all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- Boundary conditions:
  - A request dropped before its grant is not remembered.
  - Inputs of non-winning requesters are ignored.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted mid-transaction aborts it: no response is produced, rr_ptr returns to 0.

Optional Feature:
TABLE_ARB_STATS_EN
- Defined: adds output ports stat_grants (16) and stat_stalls (16), both reset to 0.
  - stat_grants increments on every IDLE grant.
  - stat_stalls increments on every RESP cycle with rsp_ready = 0.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single request: requester 0 sends data 8'h35, control 4'h2; rsp_ready held at 1 -> req_ready[0] high in the accept cycle; rsp_valid high 2 cycles later with rsp_id=0, rsp_result=16'h6666, rsp_status=4'h3.
- All-valid fairness: 4 requesters with requester i sending data 8'h05, control 4'h0, all held valid -> grant order 0,1,2,3,0; every response is result 16'h0055, status 4'h1, with the matching rsp_id.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_* outputs stable; no req_ready asserted; stat_stalls=5 with TABLE_ARB_STATS_EN.
- Wrap and skip: after serving requester 3, only requesters 1 and 2 valid -> grant goes to 1 (search wraps 0→1), then to 2; requester 2 sends control 4'h3, data 8'h03 -> result 16'h1234, status 4'h1.
- Reset mid-op: assert rst_n=0 while in LOOKUP -> rsp_valid=0 immediately; after release, rr_ptr=0 and the next grant goes to the lowest valid requester.
- Stats saturation (TABLE_ARB_STATS_EN): issue 65540 grants -> stat_grants=16'hFFFF and holds.
